// File: rtl/hs_pkg.sv
// Shared handshake-stage definitions: FSM state encoding and word geometry.
package hs_pkg;

  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int SLOTS   = WORD_W / BYTE_W;
  localparam int COUNT_W = 16;

  // Four-phase handshake states. S_REL is reserved for stages that wait
  // for request release separately; the packer returns straight to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACK  = 2'b01,
    S_REL  = 2'b10
  } hs_state_t;

endpackage

// File: rtl/hs_packer.sv
// Four-phase byte receiver that packs four bytes into a 32-bit word and
// presents it on a valid/ready interface, counting delivered words.
module hs_packer
  import hs_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] din,
  input  logic              rr,
  output logic              ar,
  output logic [WORD_W-1:0] dout,
  output logic              dvalid,
  input  logic              dready,
  output logic [COUNT_W-1:0] wcount
);

  hs_state_t          state_reg;
  logic               ar_reg;
  logic [1:0]         idx_reg;
  logic [BYTE_W-1:0]  part_reg [0:SLOTS-2];
  logic [WORD_W-1:0]  dout_reg;
  logic               dvalid_reg;
  logic [COUNT_W-1:0] wcount_reg;

  logic              last_slot;
  logic              xfer;
  logic              capture_ok;
  logic              capture;
  logic              word_done;
  logic [WORD_W-1:0] packed_word;

  // The final byte may only be taken when the output register is free or
  // is being emptied on this very edge; earlier slots never block.
  assign last_slot  = (idx_reg == 2'(SLOTS - 1));
  assign xfer       = dvalid_reg & dready;
  assign capture_ok = !last_slot || !dvalid_reg || dready;
  assign capture    = (state_reg == S_IDLE) && rr && capture_ok;
  assign word_done  = capture && last_slot;

  // Word assembly: the last byte comes straight from din so the word can be
  // loaded on the same edge the final byte is acknowledged.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_pack
      logic [BYTE_W-1:0] slot_byte;

      if (gi == SLOTS - 1) begin : g_last
        assign slot_byte = din;
      end else begin : g_held
        assign slot_byte = part_reg[gi];
      end

      if (LSB_FIRST) begin : g_lsb
        assign packed_word[gi*BYTE_W +: BYTE_W] = slot_byte;
      end else begin : g_msb
        assign packed_word[(SLOTS-1-gi)*BYTE_W +: BYTE_W] = slot_byte;
      end
    end

    for (gi = 0; gi < SLOTS - 1; gi++) begin : g_part
      // Hold partial bytes of the word under construction.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          part_reg[gi] <= '0;
        end else if (capture && (idx_reg == 2'(gi))) begin
          part_reg[gi] <= din;
        end
      end
    end
  endgenerate

  // Handshake FSM; ar is registered and moves on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      ar_reg    <= 1'b0;
      idx_reg   <= 2'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (capture) begin
            state_reg <= S_ACK;
            ar_reg    <= 1'b1;
            idx_reg   <= idx_reg + 2'd1;
          end
        end
        S_ACK: begin
          if (!rr) begin
            state_reg <= S_IDLE;
            ar_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ar_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Output word register: a new word wins over a simultaneous drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
    end else if (word_done) begin
      dout_reg   <= packed_word;
      dvalid_reg <= 1'b1;
    end else if (xfer) begin
      dvalid_reg <= 1'b0;
    end
  end

  // Delivered-word counter, free-running modulo 2^16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcount_reg <= '0;
    end else if (xfer) begin
      wcount_reg <= wcount_reg + COUNT_W'(1);
    end
  end

  assign ar     = ar_reg;
  assign dout   = dout_reg;
  assign dvalid = dvalid_reg;
  assign wcount = wcount_reg;

endmodule
